// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide issue controller: opcodes, HI/LO
// read codes, queue entry layout, FSM states and timing constants.
package md_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_HI   = 2'b01;
  localparam logic [1:0] RD_LO   = 2'b10;

  localparam int FIFO_DEPTH     = 2;
  localparam int TIMEOUT_CYCLES = 12;
  localparam int WAIT_CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_entry_t;

  localparam int ENTRY_W = $bits(md_entry_t);

  // Opcodes 0 and 7 carry no work for the unit and are never queued.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op >= OP_MULT) && (op <= OP_MTLO);
  endfunction

endpackage

// File: rtl/md_op_fifo.sv
// Two-entry operation queue with 1-bit wrapping pointers and an occupancy
// count; clear empties it in one edge and overrides push/pop.
module md_op_fifo
  import md_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: queues operations, issues
// one at a time with a one-cycle start pulse, and gates HI/LO reads.
module md_issue_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        in_ready,
  input  logic [1:0]  rd_op,
  output logic        rd_stall,
  input  logic        flush,
  output logic [2:0]  md_op,
  output logic [31:0] md_num1,
  output logic [31:0] md_num2,
  output logic        md_req,
  output logic [1:0]  hilo_rop,
  input  logic        md_busy,
  output logic        timeout_err
);

  state_e                state_reg, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic                  timeout_err_reg, timeout_set;
  md_entry_t             issue_reg, head, in_entry;
  logic [ENTRY_W-1:0]    head_bits;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;

  assign in_entry = '{op: in_op, a: in_a, b: in_b};
  assign push     = in_valid && !fifo_full && !flush && is_md_op(in_op);
  assign head     = md_entry_t'(head_bits);

  md_op_fifo #(.WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   (in_entry),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    pop           = 1'b0;
    timeout_set   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !md_busy && !flush) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A flush here cancels the start (md_req), so nothing will run.
        state_next = flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (!md_busy) begin
          state_next = ST_IDLE;
        end else if (wait_cnt_reg == WAIT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next  = ST_IDLE;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
      issue_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (timeout_set) timeout_err_reg <= 1'b1;
      if (pop)         issue_reg       <= head;
    end
  end

  assign in_ready    = !fifo_full;
  assign md_req      = flush;
  assign md_op       = (state_reg == ST_ISSUE) ? issue_reg.op : OP_NONE;
  assign md_num1     = (state_reg == ST_ISSUE) ? issue_reg.a  : 32'd0;
  assign md_num2     = (state_reg == ST_ISSUE) ? issue_reg.b  : 32'd0;
  assign timeout_err = timeout_err_reg;

  // Reads wait until nothing queued or in flight could still change HI/LO.
  assign rd_stall = (rd_op != RD_NONE) &&
                    (!fifo_empty || (state_reg != ST_IDLE) || md_busy);
  assign hilo_rop = rd_stall ? RD_NONE : rd_op;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a simple unit model: MULT/MULTU busy
// 5 cycles, DIV/DIVU busy 10 cycles, MTHI/MTLO never busy; 'stuck' forces busy.
module tb_md_issue_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready, rd_stall, flush, md_req, md_busy, timeout_err;
  logic [2:0]  in_op, md_op;
  logic [31:0] in_a, in_b, md_num1, md_num2;
  logic [1:0]  rd_op, hilo_rop;
  logic        stuck = 1'b0;
  int unsigned busy_cnt;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_a(in_a),
    .in_b(in_b), .in_ready(in_ready), .rd_op(rd_op), .rd_stall(rd_stall),
    .flush(flush), .md_op(md_op), .md_num1(md_num1), .md_num2(md_num2),
    .md_req(md_req), .hilo_rop(hilo_rop), .md_busy(md_busy),
    .timeout_err(timeout_err)
  );

  function automatic int unsigned unit_len(input logic [2:0] op);
    if (op == OP_MULT || op == OP_MULTU) return 5;
    if (op == OP_DIV || op == OP_DIVU) return 10;
    return 0;
  endfunction

  assign md_busy = stuck || (busy_cnt != 0);

  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (md_op != OP_NONE && !md_req) busy_cnt <= unit_len(md_op);
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_op = 3'd0; in_a = 32'd0; in_b = 32'd0;
    rd_op = 2'b00; flush = 1'b0;
  endtask

  // Push one op at cycle 0; return in cycle 2, the ISSUE cycle.
  task automatic push_and_reach_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; rd_op = RD_HI; flush = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (md_op !== 3'd0) begin failures++; $display("FAIL reset_md_op got=%0d exp=0", md_op); end
    checks++; if (md_num1 !== 32'd0 || md_num2 !== 32'd0) begin failures++; $display("FAIL reset_nums got=%h/%h exp=0/0", md_num1, md_num2); end
    checks++; if (md_req !== 1'b1) begin failures++; $display("FAIL reset_md_req got=%0b exp=1", md_req); end
    checks++; if (rd_stall !== 1'b0 || hilo_rop !== 2'b01) begin failures++; $display("FAIL reset_read got stall=%0b rop=%b exp stall=0 rop=01", rd_stall, hilo_rop); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", timeout_err); end
    stuck = 1'b1; #1;
    checks++; if (rd_stall !== 1'b1 || hilo_rop !== 2'b00) begin failures++; $display("FAIL reset_busy_read got stall=%0b rop=%b exp stall=1 rop=00", rd_stall, hilo_rop); end
    stuck = 1'b0; idle_inputs();
    step();
    reset = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_mult();
    int waits = 0, extra = 0;
    in_valid = 1'b1; in_op = OP_MULT; in_a = 32'd3; in_b = 32'd4; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mult_ready got=%0b exp=1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    checks++; if (md_op !== 3'd0) begin failures++; $display("FAIL mult_pre_issue got=%0d exp=0", md_op); end
    step();
    checks++; if (md_op !== 3'd1 || md_num1 !== 32'd3 || md_num2 !== 32'd4) begin failures++; $display("FAIL mult_issue got op=%0d n1=%0d n2=%0d exp op=1 n1=3 n2=4", md_op, md_num1, md_num2); end
    for (int i = 0; i < 10; i++) begin
      step();
      if (md_op !== 3'd0) extra++;
      if (dut.state_reg == ST_WAIT) waits++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL mult_single_pulse got extra=%0d exp=0", extra); end
    checks++; if (waits != 6) begin failures++; $display("FAIL mult_wait_cycles got=%0d exp=6", waits); end
    checks++; if (dut.state_reg !== ST_IDLE) begin failures++; $display("FAIL mult_end_idle got=%0d exp=%0d", dut.state_reg, ST_IDLE); end
    $display("test_mult done waits=%0d", waits);
  endtask

  task automatic test_drop();
    int bad = 0;
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd1;
    step();
    in_op = 3'd7;
    step();
    in_valid = 1'b0; rd_op = RD_LO; #1;
    checks++; if (rd_stall !== 1'b0 || hilo_rop !== RD_LO) begin failures++; $display("FAIL drop_empty got stall=%0b rop=%b exp stall=0 rop=10", rd_stall, hilo_rop); end
    rd_op = RD_NONE;
    for (int i = 0; i < 3; i++) begin
      step();
      if (md_op !== 3'd0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL drop_no_issue got=%0d exp=0", bad); end
    $display("test_drop done");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int pc [3];
    logic [31:0] pa [3];
    stuck = 1'b1;
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%0b exp=1", in_ready); end
    step();
    in_a = 32'd200; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%0b exp=1", in_ready); end
    step();
    in_a = 32'd300; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%0b exp=0", in_ready); end
    step();
    stuck = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_on_pop got=%0b exp=0", in_ready); end
    for (int c = 1; c <= 42; c++) begin
      step();
      if (c == 2) in_valid = 1'b0;
      if (md_op == OP_DIVU) begin
        if (n < 3) begin pc[n] = c; pa[n] = md_num1; end
        n++;
      end
    end
    checks++; if (n != 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", n); end
    if (n == 3) begin
      checks++; if (pa[0] !== 32'd100 || pa[1] !== 32'd200 || pa[2] !== 32'd300) begin failures++; $display("FAIL b2b_order got=%0d,%0d,%0d exp=100,200,300", pa[0], pa[1], pa[2]); end
      checks++; if (pc[1] - pc[0] != 13 || pc[2] - pc[1] != 13) begin failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=13,13", pc[1] - pc[0], pc[2] - pc[1]); end
    end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL b2b_no_timeout got=%0b exp=0", timeout_err); end
    $display("test_back_to_back done pulses=%0d", n);
  endtask

  task automatic test_mflo();
    int bad = 0, fall = -1;
    push_and_reach_issue(OP_DIV, 32'd50, 32'd5);
    checks++; if (md_op !== OP_DIV) begin failures++; $display("FAIL mflo_issue got=%0d exp=3", md_op); end
    rd_op = RD_LO; #1;
    checks++; if (rd_stall !== 1'b1 || hilo_rop !== 2'b00) begin failures++; $display("FAIL mflo_issue_stall got stall=%0b rop=%b exp stall=1 rop=00", rd_stall, hilo_rop); end
    for (int c = 3; c <= 13; c++) begin
      step();
      if (rd_stall !== 1'b1 || hilo_rop !== 2'b00) bad++;
      if (!md_busy && fall < 0) fall = c;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL mflo_held got bad_cycles=%0d exp=0", bad); end
    checks++; if (fall != 13) begin failures++; $display("FAIL mflo_busy_fall got=%0d exp=13", fall); end
    step();
    checks++; if (rd_stall !== 1'b0 || hilo_rop !== RD_LO) begin failures++; $display("FAIL mflo_release got stall=%0b rop=%b exp stall=0 rop=10", rd_stall, hilo_rop); end
    rd_op = RD_NONE;
    $display("test_mflo done");
  endtask

  task automatic test_flush_issue();
    int waits = 0;
    push_and_reach_issue(OP_MULTU, 32'd9, 32'd9);
    checks++; if (md_op !== OP_MULTU) begin failures++; $display("FAIL fl_issue_op got=%0d exp=2", md_op); end
    flush = 1'b1; #1;
    checks++; if (md_req !== 1'b1) begin failures++; $display("FAIL fl_md_req got=%0b exp=1", md_req); end
    step();
    flush = 1'b0; rd_op = RD_HI; #1;
    checks++; if (dut.state_reg !== ST_IDLE) begin failures++; $display("FAIL fl_to_idle got=%0d exp=%0d", dut.state_reg, ST_IDLE); end
    checks++; if (rd_stall !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL fl_empty got stall=%0b ready=%0b exp stall=0 ready=1", rd_stall, in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (dut.state_reg == ST_WAIT) waits++;
    end
    checks++; if (waits != 0) begin failures++; $display("FAIL fl_no_wait got=%0d exp=0", waits); end
    rd_op = RD_NONE;
    $display("test_flush_issue done");
  endtask

  task automatic test_flush_fifo();
    int bad = 0;
    stuck = 1'b1;
    in_valid = 1'b1; in_op = OP_MULT; in_a = 32'd7; in_b = 32'd8;
    step();
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; stuck = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ffl_ready got=%0b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (md_op !== 3'd0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL ffl_no_issue got=%0d exp=0", bad); end
    $display("test_flush_fifo done");
  endtask

  task automatic test_mthi();
    push_and_reach_issue(OP_MTHI, 32'hDEADBEEF, 32'd0);
    checks++; if (md_op !== OP_MTHI || md_num1 !== 32'hDEADBEEF) begin failures++; $display("FAIL mthi_issue got op=%0d n1=%h exp op=5 n1=deadbeef", md_op, md_num1); end
    rd_op = RD_HI; #1;
    checks++; if (rd_stall !== 1'b1) begin failures++; $display("FAIL mthi_stall0 got=%0b exp=1", rd_stall); end
    step();
    checks++; if (md_op !== 3'd0 || rd_stall !== 1'b1) begin failures++; $display("FAIL mthi_cycle1 got op=%0d stall=%0b exp op=0 stall=1", md_op, rd_stall); end
    step();
    checks++; if (rd_stall !== 1'b0 || hilo_rop !== RD_HI) begin failures++; $display("FAIL mthi_release got stall=%0b rop=%b exp stall=0 rop=01", rd_stall, hilo_rop); end
    rd_op = RD_NONE;
    $display("test_mthi done");
  endtask

  task automatic test_timeout();
    int waits = 0;
    push_and_reach_issue(OP_MULT, 32'd1, 32'd1);
    checks++; if (md_op !== OP_MULT) begin failures++; $display("FAIL to_issue got=%0d exp=1", md_op); end
    stuck = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dut.state_reg == ST_WAIT) waits++;
    end
    checks++; if (waits != 12) begin failures++; $display("FAIL to_wait_cycles got=%0d exp=12", waits); end
    checks++; if (dut.state_reg !== ST_IDLE) begin failures++; $display("FAIL to_idle got=%0d exp=%0d", dut.state_reg, ST_IDLE); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_flag got=%0b exp=1", timeout_err); end
    stuck = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0b exp=1", timeout_err); end
    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_cleared got=%0b exp=0", timeout_err); end
    $display("test_timeout done waits=%0d", waits);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_drop();
    test_back_to_back();
    test_mflo();
    test_flush_issue();
    test_flush_fifo();
    test_mthi();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
